fastmult_seq: RTL and testbench

Sequencing controller that builds an N×N unsigned multiplier from the existing 4×4 ROM-lookup `FastMult` datapath. It accepts one operand pair over a valid/ready handshake and steps through the (N/4)² nibble-pair lookups on a single `FastMult` instance, one lookup per clock. Partial products are shifted and accumulated, and the 2N-bit product is presented on a valid/ready output. It sits between any wide-multiply client and the shared lookup table, trading latency for a single 256-entry ROM.

---
 rtl/fastmult_seq.sv | 132 +++++++++++++
 tb/tb_fastmult_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastmult_seq.sv
// fastmult_seq: N x N unsigned multiplier sequenced over one 4x4 lookup.
// Ports: clk, reset (async active-low), io_in_* (operand handshake),
//        io_out_* (2N-bit product handshake), io_busy (stepping digits).

// 4x4 product table, one 256-entry ROM addressed by {a, b}.
module FastMult (
    input  logic [3:0] io_a,
    input  logic [3:0] io_b,
    output logic [7:0] io_out
);
    logic [7:0] rom [256];

    for (genvar a = 0; a < 256; a++) begin : g_rom
        assign rom[a] = 8'((a / 16) * (a % 16));
    end

    assign io_out = rom[{io_a, io_b}];
endmodule

module fastmult_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_in_valid,
    output logic           io_in_ready,
    input  logic [N-1:0]   io_in_lhs,
    input  logic [N-1:0]   io_in_rhs,
    output logic           io_out_valid,
    input  logic           io_out_ready,
    output logic [2*N-1:0] io_out_data,
    output logic           io_busy
);
    localparam int D  = N / 4;
    localparam int S  = D * D;
    localparam int KW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   lhs_q, lhs_d;
    logic [N-1:0]   rhs_q, rhs_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2*N-1:0] acc_q, acc_d;

    int             i_idx;
    int             j_idx;
    logic [3:0]     dig_l;
    logic [3:0]     dig_r;
    logic [7:0]     lut;
    logic [2*N-1:0] pp;

    // Step k walks lhs digits fastest: i = k mod D, j = k div D.
    always_comb begin
        i_idx = int'(k_q) % D;
        j_idx = int'(k_q) / D;
        dig_l = lhs_q[4*i_idx +: 4];
        dig_r = rhs_q[4*j_idx +: 4];
    end

    FastMult u_lut (
        .io_a   (dig_l),
        .io_b   (dig_r),
        .io_out (lut)
    );

    assign pp = (2*N)'(lut) << (4 * (i_idx + j_idx));

    always_comb begin
        state_d = state_q;
        lhs_d   = lhs_q;
        rhs_d   = rhs_q;
        k_d     = k_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (io_in_valid) begin
                    lhs_d = io_in_lhs;
                    rhs_d = io_in_rhs;
                    acc_d = '0;
                    k_d   = '0;
                    // A zero operand makes the product zero: skip BUSY.
                    if (io_in_lhs == '0 || io_in_rhs == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_q + pp;
                // k parks on the last step so digit selects stay in range.
                if (k_q == KW'(S - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (io_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lhs_q   <= '0;
            rhs_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    assign io_in_ready  = (state_q == IDLE);
    assign io_out_valid = (state_q == DONE);
    assign io_busy      = (state_q == BUSY);
    assign io_out_data  = acc_q;
endmodule

// File: tb/tb_fastmult_seq.sv
// tb_fastmult_seq: directed and randomized checks of fastmult_seq
// for N = 4, 8 and 16, scoreboarded against lhs*rhs.
module tb_fastmult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv  [3];
    logic        orr [3];
    logic [15:0] lhs [3];
    logic [15:0] rhs [3];
    logic        inr [3];
    logic        ov  [3];
    logic        bz  [3];
    logic [7:0]  od4;
    logic [15:0] od8;
    logic [31:0] od16;
    logic [31:0] od  [3];

    assign od[0] = 32'(od4);
    assign od[1] = 32'(od8);
    assign od[2] = od16;

    int vectors = 0;
    int errors  = 0;

    fastmult_seq #(.N(4)) dut4 (
        .clk(clk), .reset(rst_n),
        .io_in_valid(iv[0]), .io_in_ready(inr[0]),
        .io_in_lhs(lhs[0][3:0]), .io_in_rhs(rhs[0][3:0]),
        .io_out_valid(ov[0]), .io_out_ready(orr[0]),
        .io_out_data(od4), .io_busy(bz[0])
    );

    fastmult_seq #(.N(8)) dut8 (
        .clk(clk), .reset(rst_n),
        .io_in_valid(iv[1]), .io_in_ready(inr[1]),
        .io_in_lhs(lhs[1][7:0]), .io_in_rhs(rhs[1][7:0]),
        .io_out_valid(ov[1]), .io_out_ready(orr[1]),
        .io_out_data(od8), .io_busy(bz[1])
    );

    fastmult_seq #(.N(16)) dut16 (
        .clk(clk), .reset(rst_n),
        .io_in_valid(iv[2]), .io_in_ready(inr[2]),
        .io_in_lhs(lhs[2]), .io_in_rhs(rhs[2]),
        .io_out_valid(ov[2]), .io_out_ready(orr[2]),
        .io_out_data(od16), .io_busy(bz[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair to the N=8 unit and wait for its product.
    // lat = clock edges after the accept edge until valid is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int nbusy, output int lat,
                          output logic [15:0] data);
        int w = 0;
        while (!inr[1] && w < 50) begin
            tick();
            w++;
        end
        lhs[1] = 16'(a);
        rhs[1] = 16'(b);
        iv[1]  = 1'b1;
        tick();
        iv[1] = 1'b0;
        nbusy = 0;
        lat   = 0;
        while (!ov[1] && lat < 40) begin
            if (bz[1]) nbusy++;
            tick();
            lat++;
        end
        if (!ov[1]) lat = -1;
        data = od8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lhs[1] = 16'h00AB;
        rhs[1] = 16'h00CD;
        iv[1]  = 1'b1;
        #3;
        vectors++;
        if (inr[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b, required 1", inr[1]);
        end
        vectors++;
        if (ov[1] !== 1'b0 || bz[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_busy: got %b%b, required 00", ov[1], bz[1]);
        end
        vectors++;
        if (od8 !== 16'h0000) begin
            errors++;
            $display("FAIL rst_data: got %h, required 0000", od8);
        end
        // valid held across edges while in reset must latch nothing
        tick();
        tick();
        iv[1] = 1'b0;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (ov[1] !== 1'b0 || bz[1] !== 1'b0 || inr[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_latch: got v=%b b=%b r=%b, required 0 0 1",
                     ov[1], bz[1], inr[1]);
        end
    endtask

    task automatic test_basic();
        int nb, lat;
        logic [15:0] d;
        orr[1] = 1'b1;
        vectors++;
        if (inr[1] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b, required 1", inr[1]);
        end
        run_op(8'h12, 8'h34, nb, lat, d);
        vectors++;
        if (nb !== 4 || lat !== 4) begin
            errors++;
            $display("FAIL basic_timing: got busy=%0d lat=%0d, required 4 4", nb, lat);
        end
        vectors++;
        if (d !== 16'h03A8) begin
            errors++;
            $display("FAIL basic_data: got %h, required 03a8", d);
        end
        tick();
        vectors++;
        if (ov[1] !== 1'b0 || inr[1] !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse: got v=%b r=%b, required 0 1", ov[1], inr[1]);
        end
        vectors++;
        if (od8 !== 16'h03A8) begin
            errors++;
            $display("FAIL basic_retain: got %h, required 03a8", od8);
        end
    endtask

    task automatic test_hold();
        int nb, lat, bad;
        logic [15:0] d;
        orr[1] = 1'b0;
        run_op(8'hFF, 8'hFF, nb, lat, d);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (ov[1] !== 1'b1 || od8 !== 16'hFE01 || inr[1] !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad !== 0 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable: got %0d bad cycles v=%b, required 0 1", bad, ov[1]);
        end
        orr[1] = 1'b1;
        tick();
        vectors++;
        if (ov[1] !== 1'b0 || inr[1] !== 1'b1 || od8 !== 16'hFE01) begin
            errors++;
            $display("FAIL hold_release: got v=%b r=%b d=%h, required 0 1 fe01",
                     ov[1], inr[1], od8);
        end
    endtask

    task automatic test_zero();
        int nb, lat;
        logic [15:0] d;
        orr[1] = 1'b1;
        run_op(8'h00, 8'h5A, nb, lat, d);
        // zero pairs skip BUSY: valid is seen straight after the accept edge
        vectors++;
        if (nb !== 0 || lat !== 0 || d !== 16'h0000) begin
            errors++;
            $display("FAIL zero: got busy=%0d lat=%0d d=%h, required 0 0 0000", nb, lat, d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int w, bad;
        orr[1] = 1'b0;
        lhs[1] = 16'h000F;
        rhs[1] = 16'h00F0;
        iv[1]  = 1'b1;
        tick();
        lhs[1] = 16'h0011;
        rhs[1] = 16'h0011;
        w = 0;
        bad = 0;
        while (!ov[1] && w < 40) begin
            if (inr[1]) bad++;
            tick();
            w++;
        end
        vectors++;
        if (bad !== 0 || w !== 4 || od8 !== 16'h0E10) begin
            errors++;
            $display("FAIL b2b_first: got ready_cycles=%0d lat=%0d d=%h, required 0 4 0e10",
                     bad, w, od8);
        end
        orr[1] = 1'b1;
        tick();
        vectors++;
        if (inr[1] !== 1'b1 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got r=%b v=%b, required 1 0", inr[1], ov[1]);
        end
        tick();
        iv[1] = 1'b0;
        w = 0;
        while (!ov[1] && w < 40) begin
            tick();
            w++;
        end
        vectors++;
        if (w !== 4 || od8 !== 16'h0121) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d d=%h, required 4 0121", w, od8);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int nb, lat, seen;
        logic [15:0] d;
        orr[1] = 1'b1;
        lhs[1] = 16'h00AB;
        rhs[1] = 16'h00CD;
        iv[1]  = 1'b1;
        tick();
        iv[1] = 1'b0;
        tick();
        vectors++;
        if (bz[1] !== 1'b1 || od8 === 16'h0000) begin
            errors++;
            $display("FAIL mid_busy: got b=%b d=%h, required busy with partial sum",
                     bz[1], od8);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ov[1] !== 1'b0 || bz[1] !== 1'b0 || inr[1] !== 1'b1 || od8 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_async: got v=%b b=%b r=%b d=%h, required 0 0 1 0000",
                     ov[1], bz[1], inr[1], od8);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov[1]) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_no_valid: got %0d valid cycles, required 0", seen);
        end
        run_op(8'hAB, 8'hCD, nb, lat, d);
        vectors++;
        if (d !== 16'h88EF || lat !== 4) begin
            errors++;
            $display("FAIL mid_rerun: got d=%h lat=%0d, required 88ef 4", d, lat);
        end
        tick();
    endtask

    task automatic test_random(input int idx, input int n, input int s, input int np);
        logic [31:0] exp_q [$];
        int          acc_q [$];
        int          lat_q [$];
        int          pushed = 0;
        int          popped = 0;
        int          cyc = 0;
        bit          seen = 1'b0;
        logic [31:0] mask, a, b;
        mask = (32'h1 << n) - 32'h1;
        a = '0;
        b = '0;
        while (popped < np && cyc < np * (s + 2) * 8 + 100) begin
            if (ov[idx] && !seen) begin
                seen = 1'b1;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_n%0d_spurious: got valid d=%h, required none",
                             n, od[idx]);
                end else begin
                    if (od[idx] !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rand_n%0d_data: got %h, required %h",
                                 n, od[idx], exp_q[0]);
                    end
                    vectors++;
                    if (cyc - acc_q[0] - 1 !== lat_q[0]) begin
                        errors++;
                        $display("FAIL rand_n%0d_lat: got %0d, required %0d",
                                 n, cyc - acc_q[0] - 1, lat_q[0]);
                    end
                end
            end
            if (pushed < np) begin
                iv[idx] = ($urandom_range(0, 9) < 6);
                a = $urandom & mask;
                b = $urandom & mask;
                if ($urandom_range(0, 9) == 0) a = '0;
                if ($urandom_range(0, 9) == 0) b = '0;
            end else begin
                iv[idx] = 1'b0;
            end
            lhs[idx] = a[15:0];
            rhs[idx] = b[15:0];
            orr[idx] = ($urandom_range(0, 9) < 7);
            if (iv[idx] && inr[idx]) begin
                exp_q.push_back(a * b);
                acc_q.push_back(cyc);
                lat_q.push_back((a == 0 || b == 0) ? 0 : s);
                pushed++;
            end
            if (ov[idx] && orr[idx]) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    void'(lat_q.pop_front());
                end
                popped++;
                seen = 1'b0;
            end
            tick();
            cyc++;
        end
        vectors++;
        if (popped !== np) begin
            errors++;
            $display("FAIL rand_n%0d_count: got %0d products, required %0d", n, popped, np);
        end
        iv[idx]  = 1'b0;
        orr[idx] = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b0;
            lhs[i] = '0;
            rhs[i] = '0;
        end
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 4, 1, 800);
        test_random(1, 8, 4, 800);
        test_random(2, 16, 16, 400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
